shared_mem_ctrl: RTL and testbench

Sequencer and arbiter that lets the pipelined ARM core's instruction-fetch port and data-memory port share one single-ported, fixed-latency unified memory. It sits between `top`'s IF/MEM stages and the memory macro, granting one access at a time and returning read data. While a stage's request is outstanding it drives that stage's stall output to the hazard logic. Data (MEM stage) normally wins; a starvation limit guarantees fetch progress.

---
 rtl/mem_ctrl_pkg.sv | 26 ++
 rtl/mem_lat_counter.sv | 34 +++
 rtl/shared_mem_ctrl.sv | 132 +++++++++++++
 tb/tb_shared_mem_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
//==============================================================================
// mem_ctrl_pkg : shared FSM/grant encodings for the shared memory controller
// Revision: 1.0
//==============================================================================
`default_nettype none

package mem_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } grant_t;

endpackage

`default_nettype wire

// File: rtl/mem_lat_counter.sv
//==============================================================================
// mem_lat_counter : loadable down-counter, done flags the final count of 1
// Revision: 1.0
//==============================================================================
`default_nettype none

module mem_lat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/shared_mem_ctrl.sv
//==============================================================================
// shared_mem_ctrl : arbitrates fetch and data ports onto one fixed-latency
// single-ported memory; data has priority, bounded by a starvation limit.
// Revision: 1.0
//==============================================================================
`default_nettype none

module shared_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic [DATA_W-1:0] IRdata,
  output logic              IValid,
  input  logic              DReq,
  input  logic              DWe,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWdata,
  output logic [DATA_W-1:0] DRdata,
  output logic              DValid,
  output logic              StallF,
  output logic              StallM,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] LIM      = CNT_W'(STARVE_LIM);

  state_t           state;
  grant_t           grant;
  logic             wr_lat;
  logic [CNT_W-1:0] streak;
  logic             lat_done;
  logic             starve;
  logic             pick_d;
  logic             pick_i;

  // Data wins unless fetch has already been passed over STARVE_LIM times.
  assign starve = IReq && (streak == LIM);
  assign pick_d = DReq && !starve;
  assign pick_i = !pick_d && IReq;

  mem_lat_counter #(
    .WIDTH (CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ST_ISSUE),
    .load_val (LAT_INIT),
    .dec      (state == ST_WAIT),
    .done     (lat_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      grant    <= GNT_NONE;
      wr_lat   <= 1'b0;
      streak   <= '0;
      MemEn    <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWdata <= '0;
      IRdata   <= '0;
      DRdata   <= '0;
      IValid   <= 1'b0;
      DValid   <= 1'b0;
    end else begin
      MemEn  <= 1'b0;
      MemWe  <= 1'b0;
      IValid <= 1'b0;
      DValid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_d) begin
            grant    <= GNT_D;
            wr_lat   <= DWe;
            MemEn    <= 1'b1;
            MemWe    <= DWe;
            MemAddr  <= DAddr;
            MemWdata <= DWdata;
            if (!IReq) begin
              streak <= '0;
            end else if (streak != LIM) begin
              streak <= streak + 1'b1;
            end
            state <= ST_ISSUE;
          end else if (pick_i) begin
            grant   <= GNT_I;
            wr_lat  <= 1'b0;
            MemEn   <= 1'b1;
            MemAddr <= IAddr;
            streak  <= '0;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (lat_done) begin
            if (grant == GNT_I) begin
              IRdata <= MemRdata;
            end else if (!wr_lat) begin
              DRdata <= MemRdata;
            end
            IValid <= (grant == GNT_I);
            DValid <= (grant == GNT_D);
            state  <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign StallF = IReq & ~IValid;
  assign StallM = DReq & ~DValid;

endmodule

`default_nettype wire

// File: tb/tb_shared_mem_ctrl.sv
//==============================================================================
// tb_shared_mem_ctrl : random request traffic against a transaction-level model
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_shared_mem_ctrl;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_LIM = 4;
  localparam int N_CYC      = 1400;

  logic              clk = 1'b0;
  logic              reset;
  logic              IReq;
  logic [ADDR_W-1:0] IAddr;
  logic [DATA_W-1:0] IRdata;
  logic              IValid;
  logic              DReq;
  logic              DWe;
  logic [ADDR_W-1:0] DAddr;
  logic [DATA_W-1:0] DWdata;
  logic [DATA_W-1:0] DRdata;
  logic              DValid;
  logic              StallF;
  logic              StallM;
  logic              MemEn;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWdata;
  logic [DATA_W-1:0] MemRdata;

  shared_mem_ctrl #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MEM_LAT    (MEM_LAT),
    .STARVE_LIM (STARVE_LIM)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .IReq     (IReq),
    .IAddr    (IAddr),
    .IRdata   (IRdata),
    .IValid   (IValid),
    .DReq     (DReq),
    .DWe      (DWe),
    .DAddr    (DAddr),
    .DWdata   (DWdata),
    .DRdata   (DRdata),
    .DValid   (DValid),
    .StallF   (StallF),
    .StallM   (StallM),
    .MemEn    (MemEn),
    .MemWe    (MemWe),
    .MemAddr  (MemAddr),
    .MemWdata (MemWdata),
    .MemRdata (MemRdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Memory macro driven purely by the DUT's memory-side pins
  logic [31:0] mem [0:15];
  int          rd_cycle = -1;
  logic [31:0] rd_data  = '0;

  // Transaction-level reference: busy window per access, starvation count
  logic [31:0] ref_mem [0:15];
  bit          model_on   = 0;
  bit          just_reset = 0;
  int          free_at    = 0;
  int          issue_cyc  = -1;
  int          done_cyc   = -1;
  int          m_streak   = 0;
  int          m_gnt      = 0;
  logic [31:0] m_addr, m_wdata, m_rd;
  bit          m_we;
  logic [31:0] exp_irdata = '0;
  logic [31:0] exp_drdata = '0;
  int          n_iv = 0;
  int          n_dv = 0;
  bit          prev_iv = 0, prev_dv = 0, prev_memen = 0;

  function automatic logic [31:0] rand_addr();
    return ($urandom & 32'hFF00_0000) | ($urandom & 32'h0000_003C);
  endfunction

  task automatic step();
    bit exp_memen, exp_iv, exp_dv;
    // memory macro
    if (MemEn === 1'b1) begin
      if (MemWe === 1'b1) mem[MemAddr[5:2]] = MemWdata;
      else rd_data = mem[MemAddr[5:2]];
      rd_cycle = cyc + MEM_LAT;
    end
    if (model_on) begin
      exp_memen = (cyc == issue_cyc);
      exp_iv    = (cyc == done_cyc) && (m_gnt == 1);
      exp_dv    = (cyc == done_cyc) && (m_gnt == 2);
      if (exp_iv) exp_irdata = m_rd;
      if (exp_dv && !m_we) exp_drdata = m_rd;
      check_eq("MemEn", MemEn, exp_memen);
      check_eq("IValid", IValid, exp_iv);
      check_eq("DValid", DValid, exp_dv);
      check_eq("StallF", StallF, IReq & ~exp_iv);
      check_eq("StallM", StallM, DReq & ~exp_dv);
      check_eq("IRdata", IRdata, exp_irdata);
      check_eq("DRdata", DRdata, exp_drdata);
      if (exp_memen) begin
        check_eq("MemAddr", MemAddr, m_addr);
        check_eq("MemWe", MemWe, m_we);
        if (m_we) check_eq("MemWdata", MemWdata, m_wdata);
      end
      if (just_reset) begin
        check_eq("MemAddr_rst", MemAddr, 32'h0);
        check_eq("MemWdata_rst", MemWdata, 32'h0);
        check_eq("MemWe_rst", MemWe, 1'b0);
      end
      if (exp_iv) n_iv++;
      if (exp_dv) n_dv++;
      if (reset && cyc >= free_at) begin
        m_gnt = 0;
        if (DReq && !(IReq && m_streak == STARVE_LIM)) begin
          m_gnt   = 2;
          m_addr  = DAddr;
          m_we    = DWe;
          m_wdata = DWdata;
          m_streak = IReq ? ((m_streak < STARVE_LIM) ? m_streak + 1 : m_streak) : 0;
          if (DWe) ref_mem[DAddr[5:2]] = DWdata;
          else m_rd = ref_mem[DAddr[5:2]];
        end else if (IReq) begin
          m_gnt    = 1;
          m_addr   = IAddr;
          m_we     = 0;
          m_streak = 0;
          m_rd     = ref_mem[IAddr[5:2]];
        end
        if (m_gnt != 0) begin
          issue_cyc = cyc + 1;
          done_cyc  = cyc + MEM_LAT + 2;
          free_at   = cyc + MEM_LAT + 3;
        end
      end
    end
    just_reset = 0;
    if (!reset) begin
      model_on   = 1;
      just_reset = 1;
      free_at    = cyc + 1;
      issue_cyc  = -1;
      done_cyc   = -1;
      m_streak   = 0;
      m_gnt      = 0;
      exp_irdata = '0;
      exp_drdata = '0;
    end
    prev_iv    = (IValid === 1'b1);
    prev_dv    = (DValid === 1'b1);
    prev_memen = (MemEn === 1'b1);
    MemRdata   = (cyc == rd_cycle) ? rd_data : $urandom;
  endtask

  initial begin
    int p_req;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    reset    = 1'b0;
    IReq     = 1'b1;
    IAddr    = rand_addr();
    DReq     = 1'b1;
    DWe      = 1'b0;
    DAddr    = rand_addr();
    DWdata   = $urandom;
    MemRdata = '0;
    @(negedge clk);
    step();
    for (int c = 1; c < N_CYC; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      if (c < 2)        p_req = 100;
      else if (c < 450) p_req = 40;
      else if (c < 800) p_req = 100;
      else              p_req = 60;
      reset = !(c < 2 || (c >= 800 && prev_memen && ($urandom % 3 == 0)));
      if (c >= 2) begin
        if (!IReq || prev_iv) begin
          IReq  = ($urandom % 100) < p_req;
          IAddr = rand_addr();
        end
        if (!DReq || prev_dv) begin
          DReq   = ($urandom % 100) < p_req;
          DWe    = $urandom % 2;
          DAddr  = rand_addr();
          DWdata = $urandom;
        end
      end
      @(negedge clk);
      step();
    end
    check_eq("fetches_seen", 32'(n_iv > 20), 32'd1);
    check_eq("data_seen", 32'(n_dv > 20), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
